// File: rtl/frame_config_writer.sv
// -----------------------------------------------------------------------------
// frame_config_writer
//
// Turns a 32-bit configuration bitstream into fabric frame writes. The stream
// starts with a sync word, then carries commands. A write command names a
// column and a frame and is followed by one data word per fabric row. When all
// rows are in, the frame is committed with a one-cycle one-hot FrameStrobe.
// An end command parks the writer in DONE until the next sync word.
//
// Ports
//   UserCLK     : sole clock, rising edge
//   resetn      : synchronous active-low reset
//   in_data     : bitstream word
//   in_valid    : in_data valid
//   in_ready    : word accepted when in_valid && in_ready at a clock edge
//   FrameData   : row data, row r at [FrameBitsPerRow*(r+1)-1 : FrameBitsPerRow*r]
//   FrameStrobe : one-hot frame strobe, column c / frame f at c*MaxFramePerCol+f
//   busy        : high outside HUNT and DONE
//   done        : high in DONE
//   err         : sticky error (bad opcode or out-of-range address)
// -----------------------------------------------------------------------------
module frame_config_writer #(
   parameter int MaxFramePerCol  = 32,
   parameter int FrameBitsPerRow = 32,
   parameter int NumRows         = 3,
   parameter int NumCols         = 3
) (
   input  logic                                UserCLK,
   input  logic                                resetn,
   input  logic [31:0]                         in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [FrameBitsPerRow*NumRows-1:0]  FrameData,
   output logic [MaxFramePerCol*NumCols-1:0]   FrameStrobe,
   output logic                                busy,
   output logic                                done,
   output logic                                err
);

   localparam int          DataW    = FrameBitsPerRow * NumRows;
   localparam int          StrobeW  = MaxFramePerCol * NumCols;
   localparam int          RowW     = (NumRows > 1) ? $clog2(NumRows) : 1;
   localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
   localparam logic [7:0]  OpWrite  = 8'h01;
   localparam logic [7:0]  OpEnd    = 8'h02;

   typedef enum logic [2:0] {
      HUNT,
      CMD,
      DATA,
      STROBE,
      DONE
   } state_e;

   state_e              state_q, state_d;
   logic [RowW-1:0]     row_q, row_d;
   logic [7:0]          col_q, col_d;
   logic [7:0]          frame_q, frame_d;
   logic                discard_q, discard_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                in_ready_q, in_ready_d;
   logic [DataW-1:0]    frame_data_q, frame_data_d;
   logic [StrobeW-1:0]  frame_strobe_q, frame_strobe_d;

   logic                accept;
   logic                addr_ok;
   logic [31:0]         strobe_idx;
   logic                unused_cmd_bits;

   // Bits [23:16] of a command word carry no meaning.
   assign unused_cmd_bits = ^in_data[23:16];

   assign accept  = in_valid & in_ready_q;
   assign addr_ok = (32'(in_data[15:8]) < 32'(NumCols)) &&
                    (32'(in_data[7:0])  < 32'(MaxFramePerCol));

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d        = state_q;
      row_d          = row_q;
      col_d          = col_q;
      frame_d        = frame_q;
      discard_d      = discard_q;
      err_d          = err_q;
      frame_data_d   = frame_data_q;

      case (state_q)
         HUNT: begin
            if (accept && in_data == SyncWord) state_d = CMD;
         end

         CMD: begin
            if (accept) begin
               case (in_data[31:24])
                  OpWrite: begin
                     row_d   = '0;
                     state_d = DATA;
                     if (addr_ok) begin
                        col_d     = in_data[15:8];
                        frame_d   = in_data[7:0];
                        discard_d = 1'b0;
                     end else begin
                        // Still swallow the row words so the stream stays aligned.
                        err_d     = 1'b1;
                        discard_d = 1'b1;
                     end
                  end
                  OpEnd:   state_d = DONE;
                  default: err_d   = 1'b1;
               endcase
            end
         end

         DATA: begin
            // in_valid low simply stalls here; row_q holds.
            if (accept) begin
               if (!discard_q) begin
                  for (int r = 0; r < NumRows; r++) begin
                     if (row_q == RowW'(r))
                        frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = in_data;
                  end
               end
               if (row_q == RowW'(NumRows - 1))
                  state_d = discard_q ? CMD : STROBE;
               else
                  row_d = row_q + 1'b1;
            end
         end

         STROBE: state_d = CMD;

         DONE: begin
            if (accept && in_data == SyncWord) state_d = CMD;
         end

         default: state_d = HUNT;
      endcase

      // Outputs are registered from the next state so they line up with it.
      in_ready_d = (state_d != STROBE);
      busy_d     = (state_d != HUNT) && (state_d != DONE);
      done_d     = (state_d == DONE);
      strobe_idx = 32'(col_d) * 32'(MaxFramePerCol) + 32'(frame_d);
      frame_strobe_d = '0;
      if (state_d == STROBE) frame_strobe_d = StrobeW'(1) << strobe_idx;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before this edge.
   always_ff @(posedge UserCLK) begin
      if (!resetn) begin
         state_q        <= HUNT;
         row_q          <= '0;
         col_q          <= '0;
         frame_q        <= '0;
         discard_q      <= 1'b0;
         err_q          <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
         in_ready_q     <= 1'b1;
         frame_data_q   <= '0;
         frame_strobe_q <= '0;
      end else begin
         state_q        <= state_d;
         row_q          <= row_d;
         col_q          <= col_d;
         frame_q        <= frame_d;
         discard_q      <= discard_d;
         err_q          <= err_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
         in_ready_q     <= in_ready_d;
         frame_data_q   <= frame_data_d;
         frame_strobe_q <= frame_strobe_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign FrameData   = frame_data_q;
   assign FrameStrobe = frame_strobe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_frame_config_writer.sv
module tb_frame_config_writer;

   localparam logic [31:0] Sync = 32'hFAB0_FAB1;

   logic        UserCLK;
   logic        resetn;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [95:0] FrameData;
   logic [95:0] FrameStrobe;
   logic        busy;
   logic        done;
   logic        err;

   frame_config_writer dut (
      .UserCLK     (UserCLK),
      .resetn      (resetn),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial begin
      UserCLK = 1'b0;
      forever #5 UserCLK = ~UserCLK;
   end

   typedef struct {
      logic [95:0] strobe;
      logic [95:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [95:0] model_data;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every strobe seen must match the oldest expected frame.
   always @(negedge UserCLK) begin
      if (FrameStrobe !== '0) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", FrameStrobe, '0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_bits", FrameStrobe, e.strobe);
            check("strobe_data", FrameData, e.data);
         end
      end
   end

   // Present one word and hold it until accepted; returns 1 time unit after the edge.
   task automatic send(input logic [31:0] w);
      int n;
      @(negedge UserCLK);
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge UserCLK);
         n++;
      end
      if (n == 20) check("in_ready_timeout", in_ready, 1'b1);
      @(posedge UserCLK);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int cycles);
      repeat (cycles) begin
         @(negedge UserCLK);
         in_valid = 1'b0;
         in_data  = $urandom;
      end
   endtask

   task automatic run_frame(input logic [7:0] col, input logic [7:0] fr,
                            input logic [31:0] w0, w1, w2, input bit gaps);
      exp_t e;
      send(32'h0100_0000 | {16'h0000, col, fr});
      if (col < 8'd3 && fr < 8'd32) begin
         e.strobe   = 96'(1) << (int'(col) * 32 + int'(fr));
         e.data     = {w2, w1, w0};
         model_data = e.data;
         exp_q.push_back(e);
      end
      if (gaps) idle($urandom_range(0, 3));
      send(w0);
      if (gaps) idle($urandom_range(0, 3));
      send(w1);
      if (gaps) idle($urandom_range(0, 3));
      send(w2);
   endtask

   initial begin
      resetn     = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      model_data = '0;
      repeat (3) @(negedge UserCLK);
      check("rst_strobe", FrameStrobe, '0);
      check("rst_data", FrameData, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      resetn = 1'b1;
      @(posedge UserCLK); #1;
      check("hunt_ready", in_ready, 1'b1);

      // Garbage before sync is dropped.
      send(32'h1234_5678);
      check("garbage_busy", busy, 1'b0);
      check("garbage_err", err, 1'b0);
      send(Sync);
      check("sync_busy", busy, 1'b1);

      // Column 1, frame 5 -> bit 37, with latency check around the strobe.
      run_frame(8'd1, 8'd5, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 1'b0);
      check("strobe_cycle_ready", in_ready, 1'b0);
      check("strobe_cycle_bits", FrameStrobe, 96'(1) << 37);
      @(posedge UserCLK); #1;
      check("post_strobe_ready", in_ready, 1'b1);
      check("post_strobe_clear", FrameStrobe, '0);
      check("post_strobe_hold", FrameData, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
      check("post_strobe_err", err, 1'b0);

      // Column 3 is out of range: words swallowed, nothing written.
      run_frame(8'd3, 8'd0, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 1'b0);
      check("badcol_err", err, 1'b1);
      check("badcol_data", FrameData, model_data);
      check("badcol_busy", busy, 1'b1);
      run_frame(8'd0, 8'd0, 32'h0000_1111, 32'h0000_2222, 32'h0000_3333, 1'b0);

      // Stalls between words keep the row order.
      for (int k = 0; k < 3; k++)
         run_frame(8'd1, 8'(10 + k), $urandom, $urandom, $urandom, 1'b1);

      // Last frame of last column, then end command.
      run_frame(8'd2, 8'd31, 32'h5555_0000, 32'h6666_0000, 32'h7777_0000, 1'b0);
      send(32'h0200_0000);
      check("done_flag", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_ready", in_ready, 1'b1);
      send(32'h0100_0105);
      check("done_ignores_word", done, 1'b1);
      send(Sync);
      check("resync_done", done, 1'b0);
      check("resync_busy", busy, 1'b1);
      check("resync_err_kept", err, 1'b1);

      // Reset in the middle of row 1 abandons the frame.
      send(32'h0100_0001);
      send(32'h1111_1111);
      @(negedge UserCLK);
      in_data  = 32'h2222_2222;
      in_valid = 1'b1;
      resetn   = 1'b0;
      @(posedge UserCLK); #1;
      in_valid = 1'b0;
      @(negedge UserCLK);
      resetn = 1'b1;
      @(posedge UserCLK); #1;
      check("midrst_strobe", FrameStrobe, '0);
      check("midrst_ready", in_ready, 1'b1);
      check("midrst_data", FrameData, '0);
      check("midrst_err", err, 1'b0);
      check("midrst_busy", busy, 1'b0);
      send(32'h3333_3333);
      check("midrst_hunt", busy, 1'b0);

      // Unknown opcode flags err and stays in CMD.
      send(Sync);
      send(32'h0700_0000);
      check("badop_err", err, 1'b1);
      check("badop_busy", busy, 1'b1);
      run_frame(8'd0, 8'd1, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 1'b0);

      repeat (4) @(negedge UserCLK);
      check("scoreboard_empty", 96'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
